// File: rtl/key_search_pkg.sv
// ============================================================================
// key_search_pkg - shared types, ASCII constants and byte classifier
// Rev 1.0
// ============================================================================
`default_nettype none

package key_search_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_FOUND = 3'd4,
    ST_EXH   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CS_LOWER = 2'd0,
    CS_PRINT = 2'd1,
    CS_ALNUM = 2'd2
  } charset_e;

  localparam logic [7:0] ASC_SPACE = 8'd32;
  localparam logic [7:0] ASC_TILDE = 8'd126;
  localparam logic [7:0] ASC_D0    = 8'd48;
  localparam logic [7:0] ASC_D9    = 8'd57;
  localparam logic [7:0] ASC_UA    = 8'd65;
  localparam logic [7:0] ASC_UZ    = 8'd90;
  localparam logic [7:0] ASC_LA    = 8'd97;
  localparam logic [7:0] ASC_LZ    = 8'd122;

  // Unlisted mode encodings fall back to the lowercase + space set.
  function automatic logic is_legal(input logic [7:0] b, input logic [1:0] mode);
    logic lower;
    logic upper;
    logic digit;
    logic space;
    logic legal;
    lower = (b >= ASC_LA) && (b <= ASC_LZ);
    upper = (b >= ASC_UA) && (b <= ASC_UZ);
    digit = (b >= ASC_D0) && (b <= ASC_D9);
    space = (b == ASC_SPACE);
    if (mode == CS_PRINT) begin
      legal = (b >= ASC_SPACE) && (b <= ASC_TILDE);
    end else if (mode == CS_ALNUM) begin
      legal = lower || upper || digit || space;
    end else begin
      legal = lower || space;
    end
    return legal;
  endfunction

endpackage

`default_nettype wire

// File: rtl/char_class.sv
// ============================================================================
// char_class - combinational legality check of one decrypted byte
// Rev 1.0
// ============================================================================
`default_nettype none

module char_class
  import key_search_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic [1:0] mode_i,
  output logic       legal_o
);

  always_comb begin
    legal_o = is_legal(data_i, mode_i);
  end

endmodule

`default_nettype wire

// File: rtl/key_search_ctrl.sv
// ============================================================================
// key_search_ctrl - brute-force key search controller for the decrypt pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

module key_search_ctrl
  import key_search_pkg::*;
#(
  parameter int unsigned KEY_W     = 24,
  parameter int unsigned MSG_LEN   = 32,
  parameter int unsigned KEY_START = 0,
  parameter int unsigned KEY_END   = 2**(KEY_W-2)-1
) (
  input  logic             clok,
  input  logic             resetm,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  output logic             restart,
  input  logic             restart_ack,
  input  logic             char_valid,
  input  logic [7:0]       char_data,
  output logic             char_ready,
  output logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [KEY_W:0]   keys_tried
);

  localparam int unsigned     CNT_W       = $clog2(MSG_LEN+1);
  localparam logic [KEY_W-1:0] KEY_START_V = KEY_W'(KEY_START);
  localparam logic [KEY_W-1:0] KEY_END_V   = KEY_W'(KEY_END);
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(MSG_LEN-1);

  state_e           state_q,      state_d;
  logic [KEY_W-1:0] key_q,        key_d;
  logic [KEY_W:0]   tried_q,      tried_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [7:0]       char_q,       char_d;
  logic [1:0]       mode_q,       mode_d;
  logic             found_q,      found_d;
  logic             exhausted_q,  exhausted_d;
  logic             legal;

  char_class u_char_class (
    .data_i  (char_q),
    .mode_i  (mode_q),
    .legal_o (legal)
  );

  always_ff @(posedge clok) begin
    if (resetm) begin
      state_q     <= ST_IDLE;
      key_q       <= KEY_START_V;
      tried_q     <= '0;
      cnt_q       <= '0;
      char_q      <= '0;
      mode_q      <= CS_LOWER;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      tried_q     <= tried_d;
      cnt_q       <= cnt_d;
      char_q      <= char_d;
      mode_q      <= mode_d;
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    tried_d     = tried_q;
    cnt_d       = cnt_q;
    char_d      = char_q;
    mode_d      = mode_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;
    // Abort only moves the FSM; results of the last search stay visible.
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_FOUND, ST_EXH: begin
          if (start) begin
            state_d     = ST_ISSUE;
            key_d       = KEY_START_V;
            tried_d     = '0;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            mode_d      = mode;
          end
        end
        ST_ISSUE: begin
          if (restart_ack) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            tried_d = tried_q + (KEY_W+1)'(1);
          end
        end
        ST_WAIT: begin
          if (char_valid) begin
            state_d = ST_CHECK;
            char_d  = char_data;
          end
        end
        ST_CHECK: begin
          if (legal) begin
            if (cnt_q == LAST_CNT) begin
              state_d = ST_FOUND;
              found_d = 1'b1;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end else if (key_q == KEY_END_V) begin
            state_d     = ST_EXH;
            exhausted_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            key_d   = key_q + KEY_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    restart    = (state_q == ST_ISSUE);
    char_ready = (state_q == ST_WAIT);
    busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    key        = key_q;
    found      = found_q;
    exhausted  = exhausted_q;
    keys_tried = tried_q;
  end

endmodule

`default_nettype wire
